// File: rtl/nios_with_onchip_sdram_mem_tester.sv
// nios_with_onchip_sdram_mem_tester
//   Avalon-MM master BIST engine for the on-chip memory. It writes seed+i to
//   word i of a region, reads the region back with pipelined reads and counts
//   the words that come back different.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle start pulse (accepted only when idle/done)
//   base_addr             byte base address (bits [1:0] ignored)
//   num_words             number of 32-bit words to test
//   seed                  pattern seed
//   busy, done, pass      run status; done pulses one cycle, pass is held
//   err_count             saturating mismatch count
//   avm_*                 Avalon-MM master interface
//
// Optional build macro MEMTEST_ERRCAP_EN adds first_err_addr, first_err_data
// and first_err_valid, which capture the first mismatch of each run.
module nios_with_onchip_sdram_mem_tester #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
`ifdef MEMTEST_ERRCAP_EN
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [31:0]       first_err_data,
  output logic              first_err_valid,
`endif
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [3:0] MAX_P = 4'(MAX_PENDING);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_r, addr_r;
  logic [CNT_W-1:0]  num_r, idx, rsp_i, err_r;
  logic [31:0]       wdata_r, exp_r;
  logic [3:0]        pending;
  logic              done_r, pass_r;
  logic              start_ok, wr_acc, rd_acc, rsp_ok, mism, last_idx;
`ifdef MEMTEST_ERRCAP_EN
  logic [ADDR_W-1:0] rsp_addr, cap_addr;
  logic [31:0]       cap_data;
  logic              cap_valid;
`endif

  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign wr_acc   = avm_write && !avm_waitrequest;
  assign rd_acc   = avm_read && !avm_waitrequest;
  // Strobes arriving with nothing outstanding are stray and ignored.
  assign rsp_ok   = avm_readdatavalid && (pending != 4'd0);
  assign mism     = rsp_ok && (avm_readdata != exp_r);
  assign last_idx = (idx == num_r - CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nx = (num_words == '0) ? S_DONE : S_WRITE;
      S_WRITE:        if (wr_acc && last_idx) state_nx = S_READ;
      S_READ:         if (rd_acc && last_idx) state_nx = S_DRAIN;
      S_DRAIN:        if (rsp_i == num_r) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    avm_write      = (state == S_WRITE);
    avm_read       = (state == S_READ) && (pending < MAX_P);
    avm_address    = (avm_write || avm_read) ? addr_r : '0;
    avm_writedata  = avm_write ? wdata_r : '0;
    avm_byteenable = (avm_write || avm_read) ? '1 : '0;
    busy           = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
  end

  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;
`ifdef MEMTEST_ERRCAP_EN
  assign first_err_addr  = cap_addr;
  assign first_err_data  = cap_data;
  assign first_err_valid = cap_valid;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_r    <= '0;
      addr_r    <= '0;
      num_r     <= '0;
      idx       <= '0;
      rsp_i     <= '0;
      err_r     <= '0;
      wdata_r   <= '0;
      exp_r     <= '0;
      pending   <= '0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
`ifdef MEMTEST_ERRCAP_EN
      rsp_addr  <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_valid <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      if (start_ok) begin
        base_r    <= {base_addr[ADDR_W-1:2], 2'b00};
        addr_r    <= {base_addr[ADDR_W-1:2], 2'b00};
        num_r     <= num_words;
        idx       <= '0;
        rsp_i     <= '0;
        err_r     <= '0;
        wdata_r   <= seed;
        exp_r     <= seed;
        pending   <= '0;
        done_r    <= (num_words == '0);
        pass_r    <= (num_words == '0);
`ifdef MEMTEST_ERRCAP_EN
        rsp_addr  <= {base_addr[ADDR_W-1:2], 2'b00};
        cap_addr  <= '0;
        cap_data  <= '0;
        cap_valid <= 1'b0;
`endif
      end else begin
        // The write and read phases share one index/address pair; the last
        // write rewinds it to the base for the read pass.
        if (wr_acc) begin
          wdata_r <= wdata_r + 32'd1;
          if (last_idx) begin
            idx    <= '0;
            addr_r <= base_r;
          end else begin
            idx    <= idx + CNT_W'(1);
            addr_r <= addr_r + ADDR_W'(4);
          end
        end else if (rd_acc) begin
          idx    <= idx + CNT_W'(1);
          addr_r <= addr_r + ADDR_W'(4);
        end

        case ({rd_acc, rsp_ok})
          2'b10:   pending <= pending + 4'd1;
          2'b01:   pending <= pending - 4'd1;
          default: ;
        endcase

        if (rsp_ok) begin
          rsp_i <= rsp_i + CNT_W'(1);
          exp_r <= exp_r + 32'd1;
`ifdef MEMTEST_ERRCAP_EN
          rsp_addr <= rsp_addr + ADDR_W'(4);
`endif
        end
        if (mism && err_r != '1) err_r <= err_r + CNT_W'(1);
`ifdef MEMTEST_ERRCAP_EN
        if (mism && !cap_valid) begin
          cap_addr  <= rsp_addr;
          cap_data  <= avm_readdata;
          cap_valid <= 1'b1;
        end
`endif
        if (state == S_DRAIN && rsp_i == num_r) begin
          done_r <= 1'b1;
          pass_r <= (err_r == '0);
        end
      end
    end
  end

endmodule
